// File: rtl/cdc_hs_receiver_if.sv
// Bus between a 4-phase req/ack source and the receiving-domain endpoint:
// request/data/ack toward the source, valid/ready toward the consumer, plus status.
interface cdc_hs_receiver_if #(
  parameter int NB_DATA  = 8,
  parameter int NB_COUNT = 16
);
  logic                i_req;
  logic [NB_DATA-1:0]  i_data;
  logic                i_ready;
  logic [NB_DATA-1:0]  o_data;
  logic                o_valid;
  logic                o_ack;
  logic                o_busy;
  logic                o_err;
  logic [NB_COUNT-1:0] o_count;

  modport slave (
    input  i_req, i_data, i_ready,
    output o_data, o_valid, o_ack, o_busy, o_err, o_count
  );

  modport master (
    output i_req, i_data, i_ready,
    input  o_data, o_valid, o_ack, o_busy, o_err, o_count
  );
endinterface

// File: rtl/cdc_hs_receiver.sv
// Receive-side endpoint of a 4-phase req/ack synchronizer: syncs the request,
// captures the source-held word, offers it with valid/ready and returns o_ack.
module cdc_hs_receiver #(
  parameter int NB_DATA  = 8,
  parameter int NB_SYNC  = 2,
  parameter int NB_COUNT = 16
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  cdc_hs_receiver_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NB_SYNC-1:0]  r_req_sync;
  logic                w_req_s;
  logic [NB_DATA-1:0]  r_data;
  logic                r_valid;
  logic                r_ack;
  logic                r_busy;
  logic                r_err;
  logic [NB_COUNT-1:0] r_count;
  logic                w_valid_nxt;
  logic                w_ack_nxt;
  logic                w_busy_nxt;
  logic                w_load;
  logic                w_count_inc;
  logic                w_err_set;

  // Request synchronizer chain; the only path from the source domain
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_req_sync <= {NB_SYNC{1'b0}};
    end else begin
      r_req_sync <= {r_req_sync[NB_SYNC-2:0], bus.i_req};
    end
  end

  assign w_req_s = r_req_sync[NB_SYNC-1];

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_ack_nxt   = r_ack;
    w_load      = 1'b0;
    w_count_inc = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req_s) begin
          w_state_nxt = ST_HOLD;
          w_valid_nxt = 1'b1;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: begin
        // Request withdrawn before ack: flag it, but still deliver the word
        if (!w_req_s) begin
          w_err_set = 1'b1;
        end else begin
          w_err_set = 1'b0;
        end
        if (r_valid && bus.i_ready) begin
          w_state_nxt = ST_ACK;
          w_valid_nxt = 1'b0;
          w_ack_nxt   = 1'b1;
          w_count_inc = 1'b1;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_ACK: begin
        if (!w_req_s) begin
          w_state_nxt = ST_IDLE;
          w_ack_nxt   = 1'b0;
        end else begin
          w_state_nxt = ST_ACK;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
        w_ack_nxt   = 1'b0;
      end
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State register
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered outputs; o_data only changes on a new capture
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_data  <= {NB_DATA{1'b0}};
      r_valid <= 1'b0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_count <= {NB_COUNT{1'b0}};
    end else begin
      r_valid <= w_valid_nxt;
      r_ack   <= w_ack_nxt;
      r_busy  <= w_busy_nxt;
      r_err   <= r_err | w_err_set;
      if (w_load) begin
        r_data <= bus.i_data;
      end
      if (w_count_inc) begin
        r_count <= r_count + {{(NB_COUNT-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.o_data  = r_data;
  assign bus.o_valid = r_valid;
  assign bus.o_ack   = r_ack;
  assign bus.o_busy  = r_busy;
  assign bus.o_err   = r_err;
  assign bus.o_count = r_count;

endmodule

// File: tb/tb_cdc_hs_receiver.sv
// Directed bench for cdc_hs_receiver: cycle table for single/backpressured
// transfers, then back-to-back, violation, counter wrap and mid-transfer reset.
module tb_cdc_hs_receiver;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic mon_en;
  logic [7:0] rx_q[$];

  cdc_hs_receiver_if #(.NB_DATA(8), .NB_COUNT(16)) ifa ();
  cdc_hs_receiver_if #(.NB_DATA(8), .NB_COUNT(4))  ifb ();

  assign ifb.i_req   = ifa.i_req;
  assign ifb.i_data  = ifa.i_data;
  assign ifb.i_ready = ifa.i_ready;

  cdc_hs_receiver #(.NB_DATA(8), .NB_SYNC(2), .NB_COUNT(16)) dut_a (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (ifa)
  );

  cdc_hs_receiver #(.NB_DATA(8), .NB_SYNC(2), .NB_COUNT(4)) dut_b (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [7:0]  data;
    logic        ready;
    logic        e_valid;
    logic [7:0]  e_data;
    logic        e_ack;
    logic        e_busy;
    logic [15:0] e_count;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Accepted words, sampled midway between the input-drive edge and the active edge
  always @(negedge clk) begin
    #2;
    if (mon_en && ifa.o_valid && ifa.i_ready) rx_q.push_back(ifa.o_data);
  end

  task automatic wait_sig(input int which, input logic val, input string name);
    int n;
    logic cur;
    n = 0;
    cur = (which == 0) ? ifa.o_valid : ifa.o_ack;
    while (cur !== val && n < 40) begin
      @(negedge clk);
      n++;
      cur = (which == 0) ? ifa.o_valid : ifa.o_ack;
    end
    chk(name, 32'(cur), 32'(val));
  endtask

  task automatic send_word(input logic [7:0] d);
    ifa.i_req  = 1'b1;
    ifa.i_data = d;
    @(negedge clk);
    wait_sig(1, 1'b1, "ack_rise");
    ifa.i_req = 1'b0;
    wait_sig(1, 1'b0, "ack_fall");
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int ack_cycles;
    checks   = 0;
    failures = 0;
    mon_en   = 1'b0;
    rst_n    = 1'b0;
    ifa.i_req   = 1'b0;
    ifa.i_data  = 8'h00;
    ifa.i_ready = 1'b0;

    // rows: inputs before edge i+1, expected outputs after it
    tbl[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0};
    tbl[1]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0};
    tbl[2]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 16'd0};
    tbl[3]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 16'd1};
    tbl[4]  = '{1'b0, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 16'd1};
    tbl[5]  = '{1'b0, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 16'd1};
    tbl[6]  = '{1'b0, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 16'd1};
    tbl[7]  = '{1'b0, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 16'd1};
    tbl[8]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 16'd1};
    tbl[9]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 16'd1};
    tbl[10] = '{1'b1, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 16'd1};
    for (int i = 11; i <= 15; i++) tbl[i] = '{1'b1, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 16'd1};
    tbl[16] = '{1'b1, 8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 16'd2};
    tbl[17] = '{1'b0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b1, 16'd2};
    tbl[18] = '{1'b0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b1, 16'd2};
    tbl[19] = '{1'b0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 16'd2};

    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(ifa.o_valid), 32'd0);
    chk("rst_ack",   32'(ifa.o_ack),   32'd0);
    chk("rst_busy",  32'(ifa.o_busy),  32'd0);
    chk("rst_err",   32'(ifa.o_err),   32'd0);
    chk("rst_data",  32'(ifa.o_data),  32'd0);
    chk("rst_count", 32'(ifa.o_count), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      ifa.i_req   = tbl[i].req;
      ifa.i_data  = tbl[i].data;
      ifa.i_ready = tbl[i].ready;
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), 32'(ifa.o_valid), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_data", i),  32'(ifa.o_data),  32'(tbl[i].e_data));
      chk($sformatf("tbl%0d_ack", i),   32'(ifa.o_ack),   32'(tbl[i].e_ack));
      chk($sformatf("tbl%0d_busy", i),  32'(ifa.o_busy),  32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_count", i), 32'(ifa.o_count), 32'(tbl[i].e_count));
      chk($sformatf("tbl%0d_err", i),   32'(ifa.o_err),   32'd0);
    end

    // back-to-back words
    rx_q.delete();
    mon_en = 1'b1;
    ifa.i_ready = 1'b1;
    for (int w = 1; w <= 4; w++) send_word(8'(w));
    repeat (2) @(negedge clk);
    chk("b2b_words", 32'(rx_q.size()), 32'd4);
    for (int w = 0; w < 4; w++) begin
      if (w < rx_q.size()) chk($sformatf("b2b_word%0d", w), 32'(rx_q[w]), 32'(w + 1));
    end
    chk("b2b_count", 32'(ifa.o_count), 32'd6);
    chk("b2b_err",   32'(ifa.o_err),   32'd0);

    // request withdrawn while word pending
    rx_q.delete();
    ifa.i_ready = 1'b0;
    ifa.i_req   = 1'b1;
    ifa.i_data  = 8'h5A;
    @(negedge clk);
    wait_sig(0, 1'b1, "viol_valid_rise");
    ifa.i_req = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("viol_hold_valid", 32'(ifa.o_valid), 32'd1);
      chk("viol_hold_data",  32'(ifa.o_data),  32'h5A);
    end
    chk("viol_err_set", 32'(ifa.o_err), 32'd1);
    ifa.i_ready = 1'b1;
    ack_cycles = 0;
    repeat (6) begin
      @(negedge clk);
      if (ifa.o_ack === 1'b1) ack_cycles++;
    end
    chk("viol_ack_cycles", 32'(ack_cycles), 32'd1);
    chk("viol_delivered",  32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) chk("viol_word", 32'(rx_q[0]), 32'h5A);
    chk("viol_busy",  32'(ifa.o_busy),  32'd0);
    chk("viol_err_sticky", 32'(ifa.o_err), 32'd1);
    chk("viol_count", 32'(ifa.o_count), 32'd7);

    // counter wrap on the 4-bit instance
    pulse_reset();
    chk("wrap_err_cleared", 32'(ifa.o_err), 32'd0);
    for (int w = 0; w < 17; w++) send_word(8'(w + 16));
    chk("wrap_count16", 32'(ifa.o_count), 32'd17);
    chk("wrap_count4",  32'(ifb.o_count), 32'd1);

    // reset while in HOLD
    ifa.i_ready = 1'b0;
    ifa.i_req   = 1'b1;
    ifa.i_data  = 8'hC3;
    @(negedge clk);
    wait_sig(0, 1'b1, "hold_valid_rise");
    #2;
    rst_n = 1'b0;
    #1;
    chk("rhold_valid", 32'(ifa.o_valid), 32'd0);
    chk("rhold_ack",   32'(ifa.o_ack),   32'd0);
    chk("rhold_busy",  32'(ifa.o_busy),  32'd0);
    chk("rhold_data",  32'(ifa.o_data),  32'd0);
    chk("rhold_count", 32'(ifa.o_count), 32'd0);
    ifa.i_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rhold_idle_busy",  32'(ifa.o_busy),  32'd0);
    chk("rhold_idle_valid", 32'(ifa.o_valid), 32'd0);

    // reset while in ACK
    ifa.i_ready = 1'b1;
    ifa.i_req   = 1'b1;
    ifa.i_data  = 8'h96;
    @(negedge clk);
    wait_sig(1, 1'b1, "rack_ack_rise");
    #2;
    rst_n = 1'b0;
    #1;
    chk("rack_ack",   32'(ifa.o_ack),   32'd0);
    chk("rack_valid", 32'(ifa.o_valid), 32'd0);
    chk("rack_busy",  32'(ifa.o_busy),  32'd0);
    chk("rack_count", 32'(ifa.o_count), 32'd0);
    ifa.i_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rack_idle_busy", 32'(ifa.o_busy), 32'd0);
    chk("rack_idle_ack",  32'(ifa.o_ack),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdc_hs_receiver.md
# cdc_hs_receiver

Destination-side endpoint of a 4-phase req/ack bus synchronizer. The block lives entirely in the receiving clock domain. It synchronizes an asynchronous request, captures a source-held data word, and presents the word downstream with a valid/ready handshake. It returns an acknowledge toward the source domain. It is the receive counterpart for transfers that cross between unrelated clocks, where the source holds data stable from request rise until acknowledge rise.

## Interface
- NB_DATA, 8, data word width
- NB_SYNC, 2, synchronizer depth on i_req; legal values are 2 or more
- NB_COUNT, 16, width of the accepted-transfer counter
- i_clock  in  1  receiving-domain clock; all flops use the rising edge
- i_reset_n  in  1  reset; asynchronous assert, active-low; one clock, asynchronous active-low reset
- i_req  in  1  request from the source domain; asynchronous to i_clock; level-based 4-phase
- i_data  in  NB_DATA  source data; stable while i_req is high and o_ack is low
- i_ready  in  1  downstream ready
- o_data  out  NB_DATA  captured word; reset value 0
- o_valid  out  1  o_data is valid; reset value 0
- o_ack  out  1  acknowledge to the source domain, driven directly from a flop; reset value 0
- o_busy  out  1  high when the FSM is not in IDLE; reset value 0
- o_err  out  1  sticky protocol-violation flag; reset value 0
- o_count  out  NB_COUNT  number of accepted words; reset value 0

## Operation
- i_req passes through an NB_SYNC-flop chain to produce req_s. No other input is synchronized; i_data is sampled only under the protocol guarantee.
- FSM states: IDLE, HOLD, ACK. Reset state is IDLE.
  - IDLE → HOLD when req_s=1. On that edge: o_data<=i_data, o_valid<=1.
  - HOLD: o_valid=1 and o_data is frozen. When o_valid&i_ready is true at an edge: o_valid<=0, o_ack<=1, o_count<=o_count+1, next state ACK.
  - ACK: o_ack=1. When req_s=0: o_ack<=0, next state IDLE.
- i_ready is ignored outside HOLD.
- o_count wraps modulo 2^NB_COUNT (all-ones + 1 = 0) with no saturation.
- Protocol violation: req_s seen 0 while in HOLD sets o_err=1.
  - o_err stays set until reset.
  - The pending word is still delivered and o_ack still rises.
  - ACK then exits after one cycle because req_s is already 0.
- req_s high in ACK holds the FSM in ACK. No new capture happens until req_s has been seen low.
- o_busy = (state != IDLE), registered alongside the state.

## Timing
- i_req rises before edge 1. Then req_s=1 after edge NB_SYNC, and o_valid=1 and o_data are valid after edge NB_SYNC+1.
- With i_ready held at 1, o_valid is high for exactly one cycle. o_ack rises after edge NB_SYNC+2.
- Each cycle of i_ready=0 in HOLD adds one cycle to o_valid and delays o_ack by one cycle.
- i_req falls before edge m. Then o_ack falls after edge m+NB_SYNC.
- Minimum full round trip in receiver cycles, excluding source-side latency: 2·NB_SYNC+2.
- Reset mid-operation: all flops, including the sync chain, clear asynchronously. o_valid and o_ack drop immediately.
  - If i_req is still high after reset release, the word is captured again. This is a known duplicate, and the source must tolerate it.
- Reset release is synchronous to i_clock at system level.

## Test plan
- Single transfer, NB_SYNC=2, i_ready=1, i_data=8'hA5 → o_valid high one cycle after edge 3 with o_data=A5; o_ack rises after edge 4; o_count=1; after i_req falls, o_ack falls 2 edges later.
- Backpressure: i_ready=0 for 5 cycles while o_valid=1 → o_valid held 6 cycles, o_data stable, o_ack rises only on the edge after i_ready=1.
- Back-to-back: the source model raises i_req again right after o_ack falls, for 4 words 01,02,03,04 → delivered in order, no duplicates, o_count=4, o_err=0.
- Violation: drop i_req during HOLD → o_err=1 and stays 1, word still delivered, o_ack high exactly 1 cycle, FSM returns to IDLE.
- Wrap: NB_COUNT=4, 17 transfers → o_count reads 1.
- Reset asserted in HOLD and in ACK → all outputs 0 immediately; with i_req low at release, FSM idles with o_busy=0.
